// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC echo-train sequencer.
// The optional abort feature in the top module is enabled by defining SEQ_ABORT_EN.
package adc_seq_pkg;

    localparam int DATABUS_WIDTH_DEF  = 32;
    localparam int ECHO_CNT_WIDTH_DEF = 16;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_PRE     = 5'b00010,
        ST_WND_ON  = 5'b00100,
        ST_WND_OFF = 5'b01000,
        ST_FIN     = 5'b10000
    } seq_state_t;

    // The window must fit inside the period so that every window has a low gap.
    function automatic logic cfg_legal(input logic [63:0] num_echoes,
                                       input logic [63:0] wnd_len,
                                       input logic [63:0] echo_period);
        return (num_echoes != 64'd0) && (wnd_len != 64'd0) && (echo_period > wnd_len);
    endfunction

endpackage

// File: rtl/adc_seq_down_cnt.sv
// Loadable down-counter that stops at zero and reports terminal count.
module adc_seq_down_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_echo_train_seq.sv
// CPMG echo-train sequencer driving the acquisition window generator.
// Define SEQ_ABORT_EN to add the ABORT input and sticky ABORTED output.
module adc_echo_train_seq
    import adc_seq_pkg::*;
#(
    parameter int DATABUS_WIDTH  = DATABUS_WIDTH_DEF,
    parameter int ECHO_CNT_WIDTH = ECHO_CNT_WIDTH_DEF
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic [DATABUS_WIDTH-1:0]  FIRST_DELAY,
    input  logic [DATABUS_WIDTH-1:0]  ECHO_PERIOD,
    input  logic [DATABUS_WIDTH-1:0]  WND_LEN,
    input  logic [ECHO_CNT_WIDTH-1:0] NUM_ECHOES,
    input  logic                      ACQ_EN,
`ifdef SEQ_ABORT_EN
    input  logic                      ABORT,
    output logic                      ABORTED,
`endif
    output logic                      ACQ_WND,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [ECHO_CNT_WIDTH-1:0] ECHO_IDX,
    output logic [DATABUS_WIDTH-1:0]  SAMPLE_CNT,
    output logic                      CFG_ERR,
    output logic                      OVERRUN
);

    seq_state_t state_q, state_d;
    logic acq_wnd_q, acq_wnd_d, busy_q, busy_d, done_q, done_d;
    logic cfg_err_q, cfg_err_d, overrun_q, overrun_d;
    logic [ECHO_CNT_WIDTH-1:0] echo_idx_q, echo_idx_d;
    logic [DATABUS_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [DATABUS_WIDTH-1:0]  wnd_m1_q, wnd_m1_d, off_m1_q, off_m1_d;
`ifdef SEQ_ABORT_EN
    logic aborted_q, aborted_d;
`endif

    logic                      tmr_load, tmr_en, tmr_zero;
    logic [DATABUS_WIDTH-1:0]  tmr_val;
    logic                      ech_load, ech_en, ech_zero;
    logic [ECHO_CNT_WIDTH-1:0] ech_val;

    adc_seq_down_cnt #(.WIDTH(DATABUS_WIDTH)) u_tmr (
        .clk(CLK), .rst_n(RESET_N), .load_i(tmr_load), .load_val_i(tmr_val),
        .en_i(tmr_en), .zero_o(tmr_zero)
    );

    // Counts echoes remaining after the current window.
    adc_seq_down_cnt #(.WIDTH(ECHO_CNT_WIDTH)) u_ech (
        .clk(CLK), .rst_n(RESET_N), .load_i(ech_load), .load_val_i(ech_val),
        .en_i(ech_en), .zero_o(ech_zero)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            acq_wnd_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
            echo_idx_q   <= '0;
            sample_cnt_q <= '0;
            wnd_m1_q     <= '0;
            off_m1_q     <= '0;
`ifdef SEQ_ABORT_EN
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acq_wnd_q    <= acq_wnd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            overrun_q    <= overrun_d;
            echo_idx_q   <= echo_idx_d;
            sample_cnt_q <= sample_cnt_d;
            wnd_m1_q     <= wnd_m1_d;
            off_m1_q     <= off_m1_d;
`ifdef SEQ_ABORT_EN
            aborted_q    <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        acq_wnd_d    = acq_wnd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = cfg_err_q;
        overrun_d    = overrun_q;
        echo_idx_d   = echo_idx_q;
        sample_cnt_d = sample_cnt_q;
        wnd_m1_d     = wnd_m1_q;
        off_m1_d     = off_m1_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_val      = '0;
        ech_load     = 1'b0;
        ech_en       = 1'b0;
        ech_val      = '0;
`ifdef SEQ_ABORT_EN
        aborted_d    = aborted_q;
`endif

        if (busy_q && ACQ_EN && (sample_cnt_q != '1)) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sample_cnt_d = '0;
                    echo_idx_d   = '0;
                    overrun_d    = 1'b0;
                    wnd_m1_d     = WND_LEN - 1'b1;
                    off_m1_d     = ECHO_PERIOD - WND_LEN - 1'b1;
`ifdef SEQ_ABORT_EN
                    aborted_d    = 1'b0;
`endif
                    if (!cfg_legal(64'(NUM_ECHOES), 64'(WND_LEN), 64'(ECHO_PERIOD))) begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = ST_PRE;
                        tmr_load  = 1'b1;
                        tmr_val   = (FIRST_DELAY == '0) ? '0 : FIRST_DELAY - 1'b1;
                        ech_load  = 1'b1;
                        ech_val   = NUM_ECHOES - 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (tmr_zero) begin
                    acq_wnd_d = 1'b1;
                    state_d   = ST_WND_ON;
                    tmr_load  = 1'b1;
                    tmr_val   = wnd_m1_q;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WND_ON: begin
                if (tmr_zero) begin
                    acq_wnd_d = 1'b0;
                    if (ech_zero) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        ech_en   = 1'b1;
                        state_d  = ST_WND_OFF;
                        tmr_load = 1'b1;
                        tmr_val  = off_m1_q;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WND_OFF: begin
                if (tmr_zero) begin
                    acq_wnd_d  = 1'b1;
                    echo_idx_d = echo_idx_q + 1'b1;
                    overrun_d  = overrun_q | ACQ_EN;
                    state_d    = ST_WND_ON;
                    tmr_load   = 1'b1;
                    tmr_val    = wnd_m1_q;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef SEQ_ABORT_EN
        // Abort wins over any window rise scheduled for the same edge.
        if (ABORT && busy_q && (state_q != ST_FIN)) begin
            acq_wnd_d  = 1'b0;
            state_d    = ST_FIN;
            done_d     = 1'b1;
            aborted_d  = 1'b1;
            echo_idx_d = echo_idx_q;
            overrun_d  = overrun_q;
        end
`endif
    end

    assign ACQ_WND    = acq_wnd_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ECHO_IDX   = echo_idx_q;
    assign SAMPLE_CNT = sample_cnt_q;
    assign CFG_ERR    = cfg_err_q;
    assign OVERRUN    = overrun_q;
`ifdef SEQ_ABORT_EN
    assign ABORTED    = aborted_q;
`endif

endmodule

// File: doc/adc_echo_train_seq.md
Name: adc_echo_train_seq

Overview:
Sequencer that drives the ACQ_WND input of the ADC acquisition window generator across a CPMG echo train.
- On START it latches the train configuration, waits an initial delay, then emits NUM_ECHOES acquisition windows at a fixed echo period.
- It monitors the window generator's ACQ_EN to count acquired samples and flag overruns.
- Sits between the pulse-program/register block and the window generator.

Parameters:
DATABUS_WIDTH, 32, width of all timing/count configuration inputs and internal counters.
ECHO_CNT_WIDTH, 16, width of echo count/index.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RESET_N  in  1  asynchronous, active-low reset.
START  in  1  start pulse; sampled only in IDLE.
FIRST_DELAY  in  DATABUS_WIDTH  cycles from START sample to first ACQ_WND rise; 0 treated as 1.
ECHO_PERIOD  in  DATABUS_WIDTH  cycles between consecutive ACQ_WND rising edges.
WND_LEN  in  DATABUS_WIDTH  ACQ_WND high time in cycles, minimum 1.
NUM_ECHOES  in  ECHO_CNT_WIDTH  number of windows, minimum 1.
ACQ_EN  in  1  enable from window generator; same clock domain.
ACQ_WND  out  1  acquisition window to window generator.
BUSY  out  1  high from START acceptance until sequence end.
DONE  out  1  one-cycle pulse at sequence end.
ECHO_IDX  out  ECHO_CNT_WIDTH  index of current/last window, 0-based.
SAMPLE_CNT  out  DATABUS_WIDTH  total ACQ_EN-high cycles this sequence; saturates at all-ones.
CFG_ERR  out  1  sticky; illegal configuration at START.
OVERRUN  out  1  sticky; ACQ_EN still high when a new window rises.

Behaviour:
- Reset (RESET_N low, async): all outputs 0, state IDLE, counters 0.
- States: IDLE, PRE, WND_ON, WND_OFF, FIN.
- IDLE:
  - START=1 at edge k: latch all config inputs; clear SAMPLE_CNT, ECHO_IDX, CFG_ERR and OVERRUN.
  - Illegal config: NUM_ECHOES=0, WND_LEN=0, or ECHO_PERIOD<=WND_LEN. Set CFG_ERR=1, pulse DONE at edge k, BUSY stays 0, remain IDLE.
  - Legal config: BUSY=1 from edge k; go to PRE.
- PRE: ACQ_WND rises at edge k+max(FIRST_DELAY,1); go to WND_ON.
- WND_ON: ACQ_WND held high exactly WND_LEN cycles, then falls.
  - If more echoes remain, go to WND_OFF.
  - Otherwise go to FIN: at the fall edge e, DONE=1; at e+1, DONE=0, BUSY=0, state IDLE.
- WND_OFF: low for ECHO_PERIOD-WND_LEN cycles; ECHO_IDX increments on the next rise edge; go to WND_ON.
- Config inputs changing while BUSY have no effect. START while BUSY or in FIN is ignored.
- SAMPLE_CNT increments on every cycle ACQ_EN=1 while BUSY=1, including the FIN cycle; it holds after DONE until the next accepted START.
- OVERRUN is set if ACQ_EN=1 on the edge where ACQ_WND rises for echo index >=1. The sequence continues after an overrun.
- Counters are down-counters loaded with length-1; terminal count is 0; no wrap.
- Reset asserted mid-sequence: immediate return to reset values; no DONE pulse.

Optional Feature:
SEQ_ABORT_EN
- Defined: adds input ABORT (1 bit).
  - ABORT=1 while BUSY: ACQ_WND forced 0 at the next edge and state goes to FIN (DONE pulse, then IDLE).
  - Adds sticky output ABORTED, cleared on next accepted START.
  - ABORT has priority over a simultaneous window rise.
- Not defined: no ABORT/ABORTED ports; sequence runs only to completion or reset.

Decomposition:
- Package adc_seq_pkg: state encoding (one-hot, 5 bits, IDLE=5'b00001 … FIN=5'b10000), DATABUS_WIDTH default, config-check function (legal/illegal).
- One sub-module, adc_seq_down_cnt: loadable down-counter with load, enable and zero flag. Instantiated for the delay/on/off timer and the echo counter.

Test Plan:
- FIRST_DELAY=5, WND_LEN=4, ECHO_PERIOD=10, NUM_ECHOES=3, START at edge 0 -> ACQ_WND high cycles [5,9), [15,19), [25,29); DONE pulse at edge 29; BUSY low at 30; ECHO_IDX=2.
- Same config, ACQ_EN driven high for 3 cycles inside each window -> SAMPLE_CNT=9, OVERRUN=0.
- NUM_ECHOES=0 (or ECHO_PERIOD=4, WND_LEN=4) -> CFG_ERR=1, DONE one pulse at the START edge, ACQ_WND never rises, BUSY stays 0.
- ACQ_EN held high from first window rise through second window rise -> OVERRUN=1 at edge 15; sequence still completes with 3 windows.
- RESET_N low for 1 cycle during the second window -> ACQ_WND=0 and BUSY=0 asynchronously; no DONE; a new START afterwards runs a normal full sequence.
- SEQ_ABORT_EN defined: ABORT at edge 17 -> ACQ_WND=0 at 17, DONE at 17, ABORTED=1, BUSY low at 18.
